vliw_packet_loader: RTL and testbench

Writer side of the VLIW instruction memory. The processor fetches one 320-bit packet per cycle from instruction memory at index pc. This block builds those packets.
- Accepts a stream of 32-bit single-slot instructions, each tagged with its functional-unit slot (0..9).
- Assembles them into 10-slot packets, filling empty slots with NOP (all-zero word).
- Writes each packet to consecutive instruction-memory addresses starting at a programmable base.

---
 rtl/vliw_pkg.sv | 35 +++
 rtl/vliw_packet_loader_if.sv | 24 ++
 rtl/vliw_bundle_reg.sv | 41 ++++
 rtl/vliw_packet_loader.sv | 160 ++++++++++++++++
 tb/tb_vliw_packet_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_pkg.sv
// Shared constants, slot map and loader state encoding for the VLIW packet loader.
package vliw_pkg;

  localparam int SLOTS     = 10;
  localparam int INST_W    = 32;
  localparam int PKT_W     = SLOTS * INST_W;
  localparam int MEM_DEPTH = 1024;
  localparam int AW        = 10;
  localparam int SLOT_W    = 4;

  localparam logic [SLOT_W-1:0] SLOT_ADD0  = 4'd0;
  localparam logic [SLOT_W-1:0] SLOT_ADD1  = 4'd1;
  localparam logic [SLOT_W-1:0] SLOT_MUL   = 4'd2;
  localparam logic [SLOT_W-1:0] SLOT_FADD0 = 4'd3;
  localparam logic [SLOT_W-1:0] SLOT_FADD1 = 4'd4;
  localparam logic [SLOT_W-1:0] SLOT_FMUL  = 4'd5;
  localparam logic [SLOT_W-1:0] SLOT_LOGIC = 4'd6;
  localparam logic [SLOT_W-1:0] SLOT_LDR   = 4'd7;
  localparam logic [SLOT_W-1:0] SLOT_STR   = 4'd8;
  localparam logic [SLOT_W-1:0] SLOT_MOV   = 4'd9;

  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2,
    ST_FULL = 2'd3
  } ld_state_e;

  function automatic logic slot_valid(input logic [SLOT_W-1:0] s);
    return s < SLOT_W'(SLOTS);
  endfunction

endpackage

// File: rtl/vliw_packet_loader_if.sv
// Instruction stream in, packet write port out; the loader is the slave side.
interface vliw_packet_loader_if;
  import vliw_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [SLOT_W-1:0] in_slot;
  logic              in_eob;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [PKT_W-1:0]  wr_data;

  modport master (
    output in_valid, in_inst, in_slot, in_eob,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_inst, in_slot, in_eob,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/vliw_bundle_reg.sv
// Slot array with occupancy bitmap; clear and write may coincide (write wins for its slot).
module vliw_bundle_reg
  import vliw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [INST_W-1:0] wr_inst,
  input  logic [SLOT_W-1:0] q_slot,
  output logic              hit,
  output logic [SLOTS-1:0]  occ,
  output logic [PKT_W-1:0]  pkt
);

  logic [INST_W-1:0] word [SLOTS];

  assign hit = slot_valid(q_slot) && occ[q_slot];

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      for (int k = 0; k < SLOTS; k++) word[k] <= NOP_INST;
    end else begin
      if (clr) occ <= '0;
      if (wr && slot_valid(wr_slot)) begin
        occ[wr_slot]  <= 1'b1;
        word[wr_slot] <= wr_inst;
      end
    end
  end

  // Slot 0 lands in the MSBs; stale words in empty slots are masked to NOP.
  always_comb begin
    pkt = '0;
    for (int k = 0; k < SLOTS; k++)
      pkt[PKT_W-1-k*INST_W -: INST_W] = occ[k] ? word[k] : NOP_INST;
  end

endmodule

// File: rtl/vliw_packet_loader.sv
// Packs slot-tagged instructions into 10-slot packets and writes them to consecutive
// instruction-memory addresses; one bubble per packet, stops at the end of memory.
module vliw_packet_loader
  import vliw_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic                 flush,
  vliw_packet_loader_if.slave  bus,
  output logic                 busy,
  output logic                 full,
  output logic [AW:0]          pkt_count,
  output logic                 err_slot,
  output logic                 err_dup
);

  ld_state_e state, state_nxt;

  logic [AW-1:0]     wr_ptr;
  logic              pend_vld;
  logic [INST_W-1:0] pend_inst;
  logic [SLOT_W-1:0] pend_slot;
  logic              pend_eob;
  logic [AW-1:0]     last_addr;
  logic [PKT_W-1:0]  last_data;

  logic              b_clr;
  logic              b_wr;
  logic [SLOT_W-1:0] b_slot;
  logic [INST_W-1:0] b_inst;
  logic              hit;
  logic [SLOTS-1:0]  occ;
  logic [PKT_W-1:0]  pkt;

  logic xfer;
  logic set_eslot;
  logic set_edup;
  logic stash;
  logic last_slot;

  assign bus.in_ready = (state == ST_FILL) && !start;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign last_slot    = (wr_ptr == AW'(MEM_DEPTH - 1));

  assign bus.wr_en   = (state == ST_EMIT);
  assign bus.wr_addr = bus.wr_en ? wr_ptr : last_addr;
  assign bus.wr_data = bus.wr_en ? pkt : last_data;
  assign full        = (state == ST_FULL);
  assign busy        = (occ != '0) || pend_vld || (state == ST_EMIT);

  vliw_bundle_reg u_bundle (
    .clk     (clk),
    .rst     (rst),
    .clr     (b_clr),
    .wr      (b_wr),
    .wr_slot (b_slot),
    .wr_inst (b_inst),
    .q_slot  (bus.in_slot),
    .hit     (hit),
    .occ     (occ),
    .pkt     (pkt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    b_clr     = 1'b0;
    b_wr      = 1'b0;
    b_slot    = bus.in_slot;
    b_inst    = bus.in_inst;
    set_eslot = 1'b0;
    set_edup  = 1'b0;
    stash     = 1'b0;
    if (start) begin
      state_nxt = ST_FILL;
      b_clr     = 1'b1;
    end else begin
      case (state)
        ST_FILL: begin
          if (xfer) begin
            if (!slot_valid(bus.in_slot)) begin
              set_eslot = 1'b1;
            end else if (hit) begin
              // Collision closes the current bundle; the new word opens the next one.
              set_edup  = 1'b1;
              stash     = 1'b1;
              state_nxt = ST_EMIT;
            end else begin
              b_wr = 1'b1;
              if (bus.in_eob) state_nxt = ST_EMIT;
            end
          end
          if (flush && ((occ != '0) || b_wr)) state_nxt = ST_EMIT;
        end
        ST_EMIT: begin
          b_clr = 1'b1;
          if (last_slot) begin
            state_nxt = ST_FULL;
          end else begin
            if (pend_vld) begin
              b_wr   = 1'b1;
              b_slot = pend_slot;
              b_inst = pend_inst;
            end
            state_nxt = (pend_vld && pend_eob) ? ST_EMIT : ST_FILL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      pkt_count <= '0;
      err_slot  <= 1'b0;
      err_dup   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_inst <= '0;
      pend_slot <= '0;
      pend_eob  <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (state == ST_EMIT) begin
        last_addr <= wr_ptr;
        last_data <= pkt;
      end
      if (start) begin
        wr_ptr    <= base_addr;
        pkt_count <= '0;
        err_slot  <= 1'b0;
        err_dup   <= 1'b0;
        pend_vld  <= 1'b0;
      end else begin
        if (set_eslot) err_slot <= 1'b1;
        if (set_edup)  err_dup  <= 1'b1;
        if (stash) begin
          pend_vld  <= 1'b1;
          pend_inst <= bus.in_inst;
          pend_slot <= bus.in_slot;
          pend_eob  <= bus.in_eob;
        end
        if (state == ST_EMIT) begin
          wr_ptr    <= wr_ptr + 1'b1;
          pkt_count <= pkt_count + 1'b1;
          pend_vld  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vliw_packet_loader.sv
// Directed test-plan sequences plus random traffic, checked every cycle against a bundle/queue model.
module tb_vliw_packet_loader;
  import vliw_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          flush;
  logic          busy;
  logic          full;
  logic [AW:0]   pkt_count;
  logic          err_slot;
  logic          err_dup;

  vliw_packet_loader_if bus();

  vliw_packet_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .full      (full),
    .pkt_count (pkt_count),
    .err_slot  (err_slot),
    .err_dup   (err_dup)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the open bundle plus a queue of closed packets awaiting their write cycle.
  bit                m_started, m_full, m_eslot, m_edup;
  int                m_ptr, m_cnt;
  bit                m_occ [SLOTS];
  logic [INST_W-1:0] m_word[SLOTS];
  logic [PKT_W-1:0]  emit_q[$];
  logic [AW-1:0]     m_last_addr;
  logic [PKT_W-1:0]  m_last_data;

  function automatic bit bundle_empty();
    for (int k = 0; k < SLOTS; k++) if (m_occ[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void clear_bundle();
    for (int k = 0; k < SLOTS; k++) begin m_occ[k] = 1'b0; m_word[k] = '0; end
  endfunction

  function automatic void close_bundle();
    logic [PKT_W-1:0] p = '0;
    for (int k = 0; k < SLOTS; k++) if (m_occ[k]) p[PKT_W-1-k*INST_W -: INST_W] = m_word[k];
    emit_q.push_back(p);
    clear_bundle();
  endfunction

  function automatic void model_reset();
    m_started = 0; m_full = 0; m_eslot = 0; m_edup = 0;
    m_ptr = 0; m_cnt = 0; m_last_addr = '0; m_last_data = '0;
    clear_bundle();
    emit_q.delete();
  endfunction

  function automatic bit m_ready();
    return m_started && !m_full && (emit_q.size() == 0) && !start;
  endfunction

  task automatic step();
    bit wrote;
    bit closed;
    int sl;
    @(negedge clk);
    wrote = (emit_q.size() > 0);
    chk("in_ready", bus.in_ready, m_ready());
    chk("wr_en", bus.wr_en, wrote);
    if (wrote) begin
      chk("wr_addr", bus.wr_addr, m_ptr[AW-1:0]);
      chk("wr_data", bus.wr_data, emit_q[0]);
    end else begin
      chk("wr_addr_hold", bus.wr_addr, m_last_addr);
      chk("wr_data_hold", bus.wr_data, m_last_data);
    end
    chk("full", full, m_full);
    chk("busy", busy, !bundle_empty() || (emit_q.size() > 0));
    chk("pkt_count", pkt_count, m_cnt);
    chk("err_slot", err_slot, m_eslot);
    chk("err_dup", err_dup, m_edup);

    if (rst) begin
      model_reset();
    end else begin
      if (wrote) begin
        m_last_addr = m_ptr[AW-1:0];
        m_last_data = emit_q[0];
      end
      if (start) begin
        m_started = 1; m_full = 0; m_eslot = 0; m_edup = 0;
        m_ptr = int'(base_addr); m_cnt = 0;
        clear_bundle();
        emit_q.delete();
      end else if (wrote) begin
        void'(emit_q.pop_front());
        m_cnt++;
        if (m_ptr == MEM_DEPTH - 1) begin
          m_full = 1;
          emit_q.delete();
          clear_bundle();
        end
        m_ptr++;
      end else if (m_started && !m_full) begin
        closed = 0;
        if (bus.in_valid) begin
          sl = int'(bus.in_slot);
          if (sl >= SLOTS) begin
            m_eslot = 1;
          end else begin
            if (m_occ[sl]) begin m_edup = 1; close_bundle(); closed = 1; end
            m_occ[sl] = 1; m_word[sl] = bus.in_inst;
            if (bus.in_eob) begin close_bundle(); closed = 1; end
          end
        end
        if (flush && !closed && !bundle_empty()) close_bundle();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    start = 1; base_addr = b;
    step();
    start = 0;
  endtask

  task automatic push(input logic [SLOT_W-1:0] s, input logic [INST_W-1:0] w, input logic e);
    int guard = 0;
    bit acc   = 0;
    bus.in_valid = 1; bus.in_slot = s; bus.in_inst = w; bus.in_eob = e;
    do begin
      acc = m_ready();
      step();
      guard++;
    end while (!acc && guard < 20);
    chk("push_accepted", acc, 1'b1);
    bus.in_valid = 0; bus.in_eob = 0;
  endtask

  initial begin
    rst = 1; start = 0; base_addr = '0; flush = 0;
    bus.in_valid = 0; bus.in_slot = '0; bus.in_inst = '0; bus.in_eob = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    idle(2);

    // Two-slot bundle at base 0x010
    do_start(10'h010);
    push(SLOT_ADD0, 32'h0840_0000, 1'b0);
    push(SLOT_MOV, 32'hA0A0_0005, 1'b1);
    idle(1);
    chk("tp1_pkt_count", pkt_count, 1);

    // Three full bundles back to back
    for (int b = 0; b < 3; b++)
      for (int s = 0; s < SLOTS; s++)
        push(SLOT_W'(s), $urandom, s == SLOTS - 1);
    idle(2);
    chk("tp2_pkt_count", pkt_count, 4);

    // Slot collision, then flush of the carried-over word
    push(SLOT_MUL, 32'h1111_2222, 1'b0);
    push(SLOT_MUL, 32'h3333_4444, 1'b0);
    idle(2);
    chk("tp3_err_dup", err_dup, 1'b1);
    flush = 1; step(); flush = 0;
    idle(2);
    chk("tp3_pkt_count", pkt_count, 6);

    // Out-of-range slot is dropped
    push(4'd12, 32'hDEAD_BEEF, 1'b1);
    idle(2);
    chk("tp4_err_slot", err_slot, 1'b1);

    // Memory exhaustion at the top of the address space
    do_start(10'd1022);
    push(SLOT_ADD1, 32'h0000_0001, 1'b1);
    push(SLOT_LDR, 32'h0000_0002, 1'b1);
    bus.in_valid = 1; bus.in_slot = SLOT_STR; bus.in_inst = 32'h0000_0003; bus.in_eob = 1;
    idle(6);
    bus.in_valid = 0; bus.in_eob = 0;
    chk("tp5_full", full, 1'b1);
    chk("tp5_pkt_count", pkt_count, 2);
    chk("tp5_in_ready", bus.in_ready, 1'b0);

    // Reset mid-bundle, then flush of an empty bundle
    do_start(10'h000);
    for (int s = 0; s < 5; s++) push(SLOT_W'(s), $urandom, 1'b0);
    rst = 1; step(); rst = 0;
    chk("tp6_busy", busy, 1'b0);
    chk("tp6_wr_data", bus.wr_data, '0);
    chk("tp6_in_ready", bus.in_ready, 1'b0);
    do_start(10'h000);
    flush = 1; step(); flush = 0;
    idle(3);
    chk("tp6_pkt_count", pkt_count, 0);

    // Random traffic, with occasional re-bases near the top of memory
    do_start(10'($urandom_range(0, 900)));
    for (int i = 0; i < 4000; i++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_slot  = ($urandom_range(0, 19) == 0) ? SLOT_W'($urandom_range(10, 15))
                                                  : SLOT_W'($urandom_range(0, 9));
      bus.in_inst  = $urandom;
      bus.in_eob   = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      start        = ($urandom_range(0, 199) == 0);
      base_addr    = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(1015, 1023))
                                                 : 10'($urandom_range(0, 1023));
      rst          = ($urandom_range(0, 999) == 0);
      step();
    end
    bus.in_valid = 0; flush = 0; start = 0; rst = 0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
